// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   DATA_BITS_OFFSET : added to the 2-bit dataBits field to get 5..8 data bits
//   parityMode_t     : encoding of the parityMode input
//   txState_t        : transmitter state encoding
//   frameDataBits()  : data bit count for a dataBits setting
//   parityBit()      : parity bit for a byte under a given frame format
package uart_pkg;

  localparam int DATA_BITS_OFFSET = 5;

  typedef enum logic [1:0] {
    PARITY_SPACE = 2'b00,
    PARITY_ODD   = 2'b01,
    PARITY_EVEN  = 2'b10,
    PARITY_MARK  = 2'b11
  } parityMode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK,
    GUARD
  } txState_t;

  function automatic logic [3:0] frameDataBits(input logic [1:0] dataBits);
    return 4'(dataBits) + 4'(DATA_BITS_OFFSET);
  endfunction

  // Only the bits that are actually sent take part in the parity.
  function automatic logic parityBit(input logic [7:0]  data,
                                     input logic [1:0]  dataBits,
                                     input parityMode_t mode);
    logic [7:0] masked;
    masked = data & (8'hFF >> (2'd3 - dataBits));
    case (mode)
      PARITY_EVEN: return ^masked;
      PARITY_ODD:  return ~^masked;
      PARITY_MARK: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
//   clk, rst        : clock, asynchronous active-high reset
//   push, wrData    : write request and data (ignored when full or flushing)
//   pop, rdData     : read request; rdData shows the head entry combinationally
//   flush           : synchronous clear, takes priority over push and pop
//   full, empty     : occupancy flags
//   level           : number of stored entries (0..DEPTH)
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdData,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign level  = count;
  assign rdData = mem[rdPtr];

  assign doPush = push && !full && !flush;
  assign doPop  = pop && !empty && !flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on overflow.
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a byte FIFO in front of a serialiser with
// programmable frame format, bit period and line-break generation.
//   clk, rst       : clock, asynchronous active-high reset
//   tx             : serial output, idle high
//   dataBits       : data bits per frame minus 5
//   hasParity      : append a parity bit
//   parityMode     : 00 space, 01 odd, 10 even, 11 mark
//   extraStopBit   : send two stop bits
//   clockDivisor   : bit period minus one, in clk cycles
//   data, valid    : byte to enqueue and its write strobe
//   ready          : FIFO has room
//   flush          : empty the FIFO (frame in flight is unaffected)
//   breakReq       : hold the line low once the current frame is done
//   level          : FIFO occupancy
//   busy           : transmitter not idle
// Frame format and divisor are sampled when a byte leaves the FIFO, so input
// changes never disturb the frame being sent.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVISOR_WIDTH = 24,
  parameter int FIFO_DEPTH          = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           tx,
  input  logic [1:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic                           extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  input  logic [7:0]                     data,
  input  logic                           valid,
  output logic                           ready,
  input  logic                           flush,
  input  logic                           breakReq,
  output logic [$clog2(FIFO_DEPTH):0]    level,
  output logic                           busy
);

  localparam int DW = CLOCK_DIVISOR_WIDTH;

  logic       fifoFull;
  logic       fifoEmpty;
  logic       fifoPop;
  logic [7:0] fifoData;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (valid),
    .wrData (data),
    .pop    (fifoPop),
    .rdData (fifoData),
    .flush  (flush),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .level  (level)
  );

  assign ready = !fifoFull;

  txState_t      state,        stateNext;
  logic          txReg,        txNext;
  logic [DW-1:0] tickCount,    tickNext;
  logic [DW-1:0] divisorLatch, divisorNext;
  logic [7:0]    shiftReg,     shiftNext;
  logic [3:0]    bitsLeft,     bitsLeftNext;
  logic          parityLatch,  parityNext;
  logic          hasParLatch,  hasParNext;
  logic          stopLeft,     stopLeftNext;
  logic          bitDone;

  assign tx      = txReg;
  assign busy    = (state != IDLE);
  assign bitDone = (tickCount == divisorLatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      txReg        <= 1'b1;
      tickCount    <= '0;
      divisorLatch <= '0;
      shiftReg     <= '0;
      bitsLeft     <= '0;
      parityLatch  <= 1'b0;
      hasParLatch  <= 1'b0;
      stopLeft     <= 1'b0;
    end else begin
      state        <= stateNext;
      txReg        <= txNext;
      tickCount    <= tickNext;
      divisorLatch <= divisorNext;
      shiftReg     <= shiftNext;
      bitsLeft     <= bitsLeftNext;
      parityLatch  <= parityNext;
      hasParLatch  <= hasParNext;
      stopLeft     <= stopLeftNext;
    end
  end

  // tx is registered: txNext is the line level for the state being entered,
  // so the output changes on the same edge as the state.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    stateNext    = state;
    txNext       = txReg;
    tickNext     = bitDone ? '0 : tickCount + DW'(1);
    divisorNext  = divisorLatch;
    shiftNext    = shiftReg;
    bitsLeftNext = bitsLeft;
    parityNext   = parityLatch;
    hasParNext   = hasParLatch;
    stopLeftNext = stopLeft;
    fifoPop      = 1'b0;

    case (state)
      IDLE: begin
        txNext   = 1'b1;
        tickNext = '0;
        if (breakReq) begin
          stateNext   = BREAK;
          txNext      = 1'b0;
          divisorNext = clockDivisor;
        end else if (!fifoEmpty) begin
          fifoPop      = 1'b1;
          stateNext    = START;
          txNext       = 1'b0;
          divisorNext  = clockDivisor;
          shiftNext    = fifoData;
          bitsLeftNext = frameDataBits(dataBits);
          parityNext   = parityBit(fifoData, dataBits, parityMode_t'(parityMode));
          hasParNext   = hasParity;
          stopLeftNext = extraStopBit;
        end
      end

      START: begin
        if (bitDone) begin
          stateNext = DATA;
          txNext    = shiftReg[0];
        end
      end

      // bitsLeft counts the bit on the line plus those still to come.
      DATA: begin
        if (bitDone) begin
          if (bitsLeft > 4'd1) begin
            shiftNext    = shiftReg >> 1;
            txNext       = shiftReg[1];
            bitsLeftNext = bitsLeft - 4'd1;
          end else if (hasParLatch) begin
            stateNext = PARITY;
            txNext    = parityLatch;
          end else begin
            stateNext = STOP;
            txNext    = 1'b1;
          end
        end
      end

      PARITY: begin
        if (bitDone) begin
          stateNext = STOP;
          txNext    = 1'b1;
        end
      end

      STOP: begin
        if (bitDone) begin
          if (stopLeft) stopLeftNext = 1'b0;
          else          stateNext    = IDLE;
        end
      end

      BREAK: begin
        txNext   = 1'b0;
        tickNext = '0;
        if (!breakReq) begin
          stateNext = GUARD;
          txNext    = 1'b1;
        end
      end

      GUARD: begin
        if (bitDone) stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
        txNext    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered. Inputs are driven at the falling
// edge and outputs sampled at the falling edge. Expected frames are built
// from the byte and format as a plain list of line levels, then compared
// cycle by cycle against tx.
module tb_uart_tx_buffered;

  localparam int CDW   = 24;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tx;
  logic [1:0]     dataBits = '0;
  logic           hasParity = 1'b0;
  logic [1:0]     parityMode = '0;
  logic           extraStopBit = 1'b0;
  logic [CDW-1:0] clockDivisor = '0;
  logic [7:0]     data = '0;
  logic           valid = 1'b0;
  logic           ready;
  logic           flush = 1'b0;
  logic           breakReq = 1'b0;
  logic [4:0]     level;
  logic           busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLOCK_DIVISOR_WIDTH (CDW),
    .FIFO_DEPTH          (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx           (tx),
    .dataBits     (dataBits),
    .hasParity    (hasParity),
    .parityMode   (parityMode),
    .extraStopBit (extraStopBit),
    .clockDivisor (clockDivisor),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .flush        (flush),
    .breakReq     (breakReq),
    .level        (level),
    .busy         (busy)
  );

  task automatic set_cfg(input int nData, input bit par, input int mode,
                         input bit twoStop, input int div);
    dataBits     = 2'(nData - 5);
    hasParity    = par;
    parityMode   = 2'(mode);
    extraStopBit = twoStop;
    clockDivisor = CDW'(div);
  endtask

  task automatic push_byte(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits up to maxWait falling edges for a start bit, then checks every
  // cycle of the frame against the reference bit list.
  task automatic check_frame(input string name, input logic [7:0] b,
                             input int nData, input bit par, input int mode,
                             input bit twoStop, input int div, input int maxWait,
                             input bit scramble, input bit expectIdle);
    logic bits [12];
    int   nBits;
    int   ones;
    bit   found;
    bit   bad;
    logic got;
    nBits = 0;
    ones  = 0;
    bits[nBits++] = 1'b0;
    for (int i = 0; i < nData; i++) begin
      bits[nBits++] = b[i];
      ones += int'(b[i]);
    end
    if (par) begin
      case (mode)
        0: bits[nBits++] = 1'b0;
        1: bits[nBits++] = (ones % 2 == 0);
        2: bits[nBits++] = (ones % 2 == 1);
        default: bits[nBits++] = 1'b1;
      endcase
    end
    bits[nBits++] = 1'b1;
    if (twoStop) bits[nBits++] = 1'b1;

    found = 1'b0;
    for (int w = 0; w < maxWait && !found; w++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s start: tx=%b after %0d cycles, required start bit 0", name, tx, maxWait);
      return;
    end

    // Format inputs change while the frame is in flight; the frame must not.
    if (scramble) begin
      dataBits     = 2'($urandom);
      hasParity    = 1'($urandom);
      parityMode   = 2'($urandom);
      extraStopBit = 1'($urandom);
      clockDivisor = CDW'($urandom_range(0, 9));
      data         = 8'($urandom);
    end

    for (int k = 0; k < nBits; k++) begin
      bad = 1'b0;
      got = bits[k];
      for (int c = 0; c <= div; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (tx !== bits[k]) begin
          bad = 1'b1;
          got = tx;
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit%0d: tx=%b required %b", name, k, got, bits[k]);
      end
    end

    if (expectIdle) begin
      @(negedge clk);
      checks++;
      if ({tx, busy} !== 2'b10) begin
        errors++;
        $display("FAIL %s idle: tx=%b busy=%b required tx=1 busy=0", name, tx, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(2);
    checks++;
    if ({tx, busy, ready, level} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b ready=%b level=%0d required 1 0 1 0",
               tx, busy, ready, level);
    end
    rst = 1'b0;
    bad_idle("reset_no_frame", 10);
  endtask

  // Line must stay idle for n cycles.
  task automatic bad_idle(input string name, input int n);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({tx, busy} !== 2'b10) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: tx=%b busy=%b required tx=1 busy=0 throughout", name, tx, busy);
    end
  endtask

  task automatic test_fixed_frames();
    set_cfg(8, 0, 0, 0, 3);
    push_byte(8'h55);
    check_frame("8n1_0x55", 8'h55, 8, 0, 0, 0, 3, 10, 0, 1);
    set_cfg(7, 1, 2, 1, 1);
    push_byte(8'h41);
    check_frame("7e2_0x41", 8'h41, 7, 1, 2, 1, 1, 10, 0, 1);
    set_cfg(5, 1, 1, 0, 0);
    push_byte(8'h1F);
    check_frame("5o1_0x1F", 8'h1F, 5, 1, 1, 0, 0, 10, 0, 1);
    push_byte(8'hE0);
    check_frame("5o1_0xE0", 8'hE0, 5, 1, 1, 0, 0, 10, 0, 1);
    set_cfg(6, 1, 3, 0, 2);
    push_byte(8'h00);
    check_frame("6m1_0x00", 8'h00, 6, 1, 3, 0, 2, 10, 0, 1);
    set_cfg(8, 1, 0, 0, 0);
    push_byte(8'hFF);
    check_frame("8s1_0xFF", 8'hFF, 8, 1, 0, 0, 0, 10, 0, 1);
  endtask

  task automatic test_random_frames();
    int          nData;
    bit          par;
    int          mode;
    bit          twoStop;
    int          div;
    logic [7:0]  b;
    for (int i = 0; i < 12; i++) begin
      nData   = $urandom_range(5, 8);
      par     = 1'($urandom);
      mode    = $urandom_range(0, 3);
      twoStop = 1'($urandom);
      div     = $urandom_range(0, 3);
      b       = 8'($urandom);
      set_cfg(nData, par, mode, twoStop, div);
      push_byte(b);
      check_frame("random", b, nData, par, mode, twoStop, div, 10, 1, 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
    set_cfg(6, 1, 1, 0, 2);
    fork
      begin
        for (int k = 0; k < 4; k++)
          check_frame("b2b", bytes[k], 6, 1, 1, 0, 2, (k == 0) ? 10 : 2, 0, k == 3);
      end
      begin
        for (int k = 0; k < 4; k++) push_byte(bytes[k]);
      end
    join
  endtask

  task automatic test_break_fill();
    logic [7:0] q [$];
    bit         wasReady;
    set_cfg(8, 0, 0, 0, 0);
    breakReq = 1'b1;
    idle_cycles(2);
    checks++;
    if ({tx, busy} !== 2'b01) begin
      errors++;
      $display("FAIL break_line: tx=%b busy=%b required tx=0 busy=1", tx, busy);
    end
    wasReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready !== 1'b1) wasReady = 1'b0;
      q.push_back(8'($urandom));
      push_byte(q[$]);
    end
    checks++;
    if (!wasReady || level !== 5'(q.size()) || ready !== 1'b0) begin
      errors++;
      $display("FAIL break_full: level=%0d ready=%b required level=%0d ready=0",
               level, ready, q.size());
    end
    push_byte(8'hC3);
    checks++;
    if (level !== 5'(q.size()) || tx !== 1'b0) begin
      errors++;
      $display("FAIL write_when_full: level=%0d tx=%b required level=%0d tx=0",
               level, tx, q.size());
    end
    breakReq = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      check_frame("after_break", q[k], 8, 0, 0, 0, 0, (k == 0) ? 6 : 2, 0, k == DEPTH - 1);
    checks++;
    if (level !== 5'd0) begin
      errors++;
      $display("FAIL drained_level: level=%0d required 0", level);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_cfg(8, 0, 0, 0, 3);
    for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i));
    checks++;
    if (level !== 5'd3) begin
      errors++;
      $display("FAIL queued_level: level=%0d required 3", level);
    end
    idle_cycles(6);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx, busy, ready, level} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b ready=%b level=%0d required 1 0 1 0",
               tx, busy, ready, level);
    end
    @(negedge clk);
    rst = 1'b0;
    bad_idle("post_reset_no_frame", 50);
    push_byte(8'hA5);
    check_frame("post_reset", 8'hA5, 8, 0, 0, 0, 3, 10, 0, 1);
  endtask

  task automatic test_flush();
    set_cfg(8, 0, 0, 0, 3);
    fork
      check_frame("flush_frame", 8'h3C, 8, 0, 0, 0, 3, 10, 0, 1);
      begin
        push_byte(8'h3C);
        idle_cycles(2);
        for (int i = 0; i < 5; i++) push_byte(8'(8'h80 + i));
        checks++;
        if (level !== 5'd5) begin
          errors++;
          $display("FAIL pre_flush_level: level=%0d required 5", level);
        end
        flush = 1'b1;
        push_byte(8'h99);
        flush = 1'b0;
        checks++;
        if (level !== 5'd0 || ready !== 1'b1) begin
          errors++;
          $display("FAIL flush_level: level=%0d ready=%b required 0 1", level, ready);
        end
      end
    join
    bad_idle("post_flush_no_frame", 60);
  endtask

  initial begin
    test_reset();
    test_fixed_frames();
    test_random_frames();
    test_back_to_back();
    test_break_fill();
    test_reset_mid_frame();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
